// File: rtl/seq_detector_pkg.sv
// Shared definitions for the "three consecutive ones" serial detector:
// state encoding and pattern length.
package seq_detector_pkg;

    typedef logic [1:0] state_t;

    localparam state_t S0 = 2'b00;  // no 1 seen
    localparam state_t S1 = 2'b01;  // one 1
    localparam state_t S2 = 2'b10;  // two consecutive 1s
    localparam state_t S3 = 2'b11;  // three or more consecutive 1s

    localparam int DETECT_LEN = 3;

endpackage : seq_detector_pkg

// File: rtl/seq_detector_111.sv
// Moore FSM that flags three or more consecutive 1s on a serial input
// (overlapping). The state register is exposed for debug.
module seq_detector_111
    import seq_detector_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       in,
    output logic       out,
    output logic [1:0] state
);

    state_t state_q;
    state_t state_d;

    // NOTE: every path assigns state_d, so no latch is inferred.
    always_comb begin
        state_d = S0;
        case (state_q)
            S0:      state_d = in ? S1 : S0;
            S1:      state_d = in ? S2 : S0;
            S2:      state_d = in ? S3 : S0;
            S3:      state_d = in ? S3 : S0;
            default: state_d = S0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignment only.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S0;
        end else begin
            state_q <= state_d;
        end
    end

    // Decoded only from the register, so out never follows in combinationally.
    assign out   = (state_q == S3);
    assign state = state_q;

endmodule : seq_detector_111

// File: tb/tb_seq_detector_111.sv
// Directed bench for seq_detector_111: each step drives reset/in for one edge
// and checks the hand-computed state and out just after that edge.
module tb_seq_detector_111;
    import seq_detector_pkg::*;

    logic       clk = 1'b0;
    logic       reset_r = 1'b0;
    logic       tb_in = 1'b0;
    logic       tb_out;
    logic [1:0] tb_state;

    int n_cmp = 0;
    int n_err = 0;

    seq_detector_111 dut (
        .clk   (clk),
        .reset (reset_r),
        .in    (tb_in),
        .out   (tb_out),
        .state (tb_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [1:0] got, input logic [1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step(input logic r, input logic b, input logic [1:0] exp_state,
                        input logic exp_out, input string tag);
        reset_r = r;
        tb_in   = b;
        @(posedge clk);
        #1;
        check({tag, "_state"}, tb_state, exp_state);
        check({tag, "_out"}, {1'b0, tb_out}, {1'b0, exp_out});
    endtask

    initial begin
        logic [1:0] t3_state [7] = '{2'b01, 2'b10, 2'b11, 2'b11, 2'b11, 2'b11, 2'b00};
        logic       t3_out   [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic       t4_in    [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [1:0] t4_state [8] = '{2'b01, 2'b10, 2'b11, 2'b00, 2'b01, 2'b10, 2'b11, 2'b00};
        logic       t4_out   [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        int         pulse_len;

        // 1: reset held low while in toggles, then release with in = 1
        for (int i = 0; i < 5; i++) step(1'b0, (i % 2 == 0), 2'b00, 1'b0, "rst_hold");
        step(1'b1, 1'b1, 2'b01, 1'b0, "rst_release");
        step(1'b1, 1'b0, 2'b00, 1'b0, "rst_release_zero");

        // 2: run of two ones never detects
        step(1'b1, 1'b1, 2'b01, 1'b0, "run2_a");
        step(1'b1, 1'b1, 2'b10, 1'b0, "run2_b");
        step(1'b1, 1'b0, 2'b00, 1'b0, "run2_c");

        // 3: run of six ones -> out high for 4 cycles
        pulse_len = 0;
        for (int i = 0; i < 7; i++) begin
            step(1'b1, (i < 6), t3_state[i], t3_out[i], $sformatf("run6_%0d", i));
            if (tb_out) pulse_len++;
        end
        check("run6_len", pulse_len[1:0] == 2'(6 - (DETECT_LEN - 1)) && pulse_len < 4'd5 ? 2'b01 : 2'b00,
              2'b01);

        // 4: 1,1,1,0,1,1,1 -> two separate one-cycle pulses
        for (int i = 0; i < 8; i++)
            step(1'b1, t4_in[i], t4_state[i], t4_out[i], $sformatf("split_%0d", i));

        // 5: reset from S3 with in = 1, then re-detect
        step(1'b1, 1'b1, 2'b01, 1'b0, "midrst_a");
        step(1'b1, 1'b1, 2'b10, 1'b0, "midrst_b");
        step(1'b1, 1'b1, 2'b11, 1'b1, "midrst_c");
        step(1'b0, 1'b1, 2'b00, 1'b0, "midrst_rst");
        step(1'b1, 1'b1, 2'b01, 1'b0, "midrst_d");
        step(1'b1, 1'b1, 2'b10, 1'b0, "midrst_e");
        step(1'b1, 1'b1, 2'b11, 1'b1, "midrst_f");
        step(1'b1, 1'b0, 2'b00, 1'b0, "midrst_g");

        // 6: alternating input never detects
        for (int i = 0; i < 10; i++)
            step(1'b1, (i % 2 == 0), (i % 2 == 0) ? 2'b01 : 2'b00, 1'b0,
                 $sformatf("alt_%0d", i));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_seq_detector_111
